// File: rtl/riscv16_pkg.sv
// Shared types and constants for the 16-bit RISC-V core front end.
// Holds the default widths, opcode encodings, field positions and fetch FSM states.
package riscv16_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INSTR_W = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_REQ   = 2'b01,
    S_WAIT  = 2'b10,
    S_STALL = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer used when decode back-pressures the fetch output.
// Clear beats load, and load beats drain, so load and drain in the same cycle refill it.
module fetch_skid_buf
  import riscv16_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               full,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  // Buffer occupancy and payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full      <= 1'b1;
      out_instr <= in_instr;
      out_pc    <= in_pc;
    end else if (drain) begin
      full <= 1'b0;
    end else begin
      full <= full;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one imem read at a time, handles redirects
// and hands {instr, pc} to decode through a registered output plus a one-entry skid buffer.
module fetch_stage
  import riscv16_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [6:0]         id_opcode,
  output logic [2:0]         id_funct3,
  output logic [6:0]         id_funct7
);

  fetch_state_e       state;
  fetch_state_e       state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  req_pc;
  logic               outstanding;
  logic               discard;
  logic               req_fire;
  logic               rsp_now;
  logic               rsp_accept;
  logic               out_fire;
  logic               out_load;
  logic               discard_set;
  logic               skid_load;
  logic               skid_drain;
  logic               skid_full;
  logic               skid_full_nxt;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  assign imem_req_valid = (state == S_REQ) && !skid_full;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding are stale (e.g. across a reset) and ignored.
  assign rsp_now        = imem_rsp_valid && outstanding;
  assign rsp_accept     = rsp_now && !discard && !redirect_valid;
  assign out_fire       = id_valid && id_ready;
  assign out_load       = !id_valid || out_fire;
  assign discard_set    = (outstanding && !rsp_now) || req_fire;
  assign skid_full_nxt  = skid_load || (skid_full && !skid_drain);

  assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
  assign id_funct3 = id_instr[FUNCT3_MSB:FUNCT3_LSB];
  assign id_funct7 = id_instr[FUNCT7_MSB:FUNCT7_LSB];

  // Route accepted responses: output register when it frees up, otherwise the skid
  always_comb begin
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (out_load) begin
      skid_drain = skid_full;
      skid_load  = rsp_accept && skid_full;
    end else begin
      skid_load  = rsp_accept;
    end
  end

  // Fetch FSM next state; a redirect overrides every state
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = discard_set ? S_WAIT : S_REQ;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_REQ;
        S_REQ:   state_nxt = req_fire ? S_WAIT : S_REQ;
        S_WAIT:  state_nxt = rsp_now ? (skid_full_nxt ? S_STALL : S_REQ) : S_WAIT;
        S_STALL: state_nxt = skid_full ? S_STALL : S_REQ;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // PC, request tracking and decode output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
    end else begin
      if (req_fire) begin
        outstanding <= 1'b1;
        req_pc      <= pc;
      end else if (rsp_now) begin
        outstanding <= 1'b0;
      end
      if (redirect_valid) begin
        pc       <= redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
        discard  <= discard_set;
        id_valid <= 1'b0;
      end else begin
        if (req_fire) begin
          pc <= pc + ADDR_W'(PC_STEP);
        end
        if (rsp_now && discard) begin
          discard <= 1'b0;
        end
        if (out_load) begin
          if (skid_full) begin
            id_valid <= 1'b1;
            id_instr <= skid_instr;
            id_pc    <= skid_pc;
          end else if (rsp_accept) begin
            id_valid <= 1'b1;
            id_instr <= imem_rsp_data;
            id_pc    <= req_pc;
          end else begin
            id_valid <= 1'b0;
          end
        end
      end
    end
  end

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (redirect_valid),
    .in_instr  (imem_rsp_data),
    .in_pc     (req_pc),
    .full      (skid_full),
    .out_instr (skid_instr),
    .out_pc    (skid_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small instruction memory with configurable latency,
// decode-side handshake logging and hand-computed expectations per scenario.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [15:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;

  int          checks;
  int          errors;
  int          mem_lat;
  int          pend_cnt;
  logic [15:0] pend_addr;
  logic [15:0] issued[$];
  logic [15:0] dlv_pc[$];
  logic [31:0] dlv_instr[$];
  int          iss0;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_opcode      (id_opcode),
    .id_funct3      (id_funct3),
    .id_funct7      (id_funct7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == 16'h0200) return 32'h00A28293;
    return {a ^ 16'h5A5A, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: log handshakes before the edge, model memory latency, return at negedge.
  task automatic tick();
    logic        fire;
    logic [15:0] a;
    fire = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    if (id_valid && id_ready) begin
      dlv_pc.push_back(id_pc);
      dlv_instr.push_back(id_instr);
    end
    @(posedge clk);
    if (fire) begin
      issued.push_back(a);
      pend_cnt  = mem_lat;
      pend_addr = a;
    end
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    if (pend_cnt != 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
      end
    end
  endtask

  task automatic wait_req(input int bound);
    int n;
    n = 0;
    while (!imem_req_valid && n < bound) begin
      tick();
      n++;
    end
    check("req_wait", 32'(imem_req_valid), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mem_lat = 1;
    pend_cnt = 0;
    pend_addr = 16'h0000;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0000_0000;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    id_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_id_instr", id_instr, 32'h0000_0000);
    check("rst_id_pc", 32'(id_pc), 32'h0000_0000);
    rst_n = 1'b1;
    tick();
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", 32'(imem_req_addr), 32'h0000_0000);

    // Streaming with a one-cycle memory
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    for (int n = 0; n < 40 && dlv_pc.size() < 3; n++) tick();
    check("seq_count", 32'(dlv_pc.size()), 32'd3);
    check("seq_addr0", 32'(issued[0]), 32'h0000_0000);
    check("seq_addr1", 32'(issued[1]), 32'h0000_0004);
    check("seq_addr2", 32'(issued[2]), 32'h0000_0008);
    check("seq_pc0", 32'(dlv_pc[0]), 32'h0000_0000);
    check("seq_pc1", 32'(dlv_pc[1]), 32'h0000_0004);
    check("seq_pc2", 32'(dlv_pc[2]), 32'h0000_0008);
    check("seq_instr0", dlv_instr[0], 32'h5A5A_0000);
    check("seq_instr1", dlv_instr[1], 32'h5A5E_0004);
    check("seq_instr2", dlv_instr[2], 32'h5A52_0008);

    // Decode back-pressure fills output and skid, then fetch stalls
    id_ready = 1'b0;
    iss0 = issued.size();
    repeat (6) tick();
    check("bp_extra_fires", 32'(issued.size() - iss0), 32'd1);
    check("bp_req_valid", 32'(imem_req_valid), 32'd0);
    check("bp_id_valid", 32'(id_valid), 32'd1);
    check("bp_id_pc", 32'(id_pc), 32'h0000_000C);
    check("bp_id_instr", id_instr, 32'h5A56_000C);
    id_ready = 1'b1;
    for (int n = 0; n < 20 && dlv_pc.size() < 5; n++) tick();
    check("drain_count", 32'(dlv_pc.size()), 32'd5);
    check("drain_pc3", 32'(dlv_pc[3]), 32'h0000_000C);
    check("drain_pc4", 32'(dlv_pc[4]), 32'h0000_0010);
    check("drain_instr4", dlv_instr[4], 32'h5A4A_0010);

    // Redirect while waiting: returning word is dropped
    mem_lat = 3;
    wait_req(10);
    check("pre_redir_addr", 32'(imem_req_addr), 32'h0000_0014);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0102;
    tick();
    redirect_valid = 1'b0;
    wait_req(10);
    check("redir_addr", 32'(imem_req_addr), 32'h0000_0100);
    check("redir_id_valid", 32'(id_valid), 32'd0);
    check("redir_dropped", 32'(dlv_pc.size()), 32'd5);

    // Redirect coinciding with the response
    mem_lat = 1;
    tick();
    check("coinc_rsp", 32'(imem_rsp_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    tick();
    redirect_valid = 1'b0;
    check("coinc_req_valid", 32'(imem_req_valid), 32'd1);
    check("coinc_addr", 32'(imem_req_addr), 32'h0000_0200);
    tick();
    tick();
    check("coinc_id_valid", 32'(id_valid), 32'd1);
    check("coinc_id_pc", 32'(id_pc), 32'h0000_0200);
    check("field_instr", id_instr, 32'h00A2_8293);
    check("field_opcode", 32'(id_opcode), 32'h0000_0013);
    check("field_funct3", 32'(id_funct3), 32'h0000_0000);
    check("field_funct7", 32'(id_funct7), 32'h0000_0000);
    check("coinc_dropped", 32'(dlv_pc.size()), 32'd5);

    // Redirect while a request fires, to an unaligned target near the top of memory
    check("wp_req_addr", 32'(imem_req_addr), 32'h0000_0204);
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("wp_id_valid", 32'(id_valid), 32'd0);
    check("wp_req_valid", 32'(imem_req_valid), 32'd1);
    check("wp_aligned_addr", 32'(imem_req_addr), 32'h0000_FFFC);
    check("wp_count", 32'(dlv_pc.size()), 32'd6);
    tick();
    tick();
    check("wrap_id_pc", 32'(id_pc), 32'h0000_FFFC);
    check("wrap_id_instr", id_instr, 32'hA5A6_FFFC);
    check("wrap_addr", 32'(imem_req_addr), 32'h0000_0000);

    // Reset while waiting on a slow response
    id_ready = 1'b0;
    mem_lat = 3;
    tick();
    check("prerst_id_valid", 32'(id_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_id_valid", 32'(id_valid), 32'd0);
    check("rst_async_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    imem_req_ready = 1'b0;
    tick();
    check("late_rsp_seen", 32'(imem_rsp_valid), 32'd1);
    tick();
    check("late_rsp_ignored", 32'(id_valid), 32'd0);
    check("postrst_req_valid", 32'(imem_req_valid), 32'd1);
    check("postrst_addr", 32'(imem_req_addr), 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
